// File: rtl/cc_demux_12.sv
// cc_demux_12: packet-locked 1-to-2 stream demux with one output register per channel; optional CC_DEMUX_12_COUNT_EN adds per-channel handshake counters
module cc_demux_12 #(
  parameter int NUMBER_DATAWIDTH = 8
) (
  input  logic                        CC_DEMUX_12_CLOCK_50,
  input  logic                        CC_DEMUX_12_RESET_InLow,
  input  logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data_InBUS,
  input  logic                        CC_DEMUX_12_valid_In,
  input  logic                        CC_DEMUX_12_last_In,
  input  logic                        CC_DEMUX_12_select_In,
  output logic                        CC_DEMUX_12_ready_Out,
  output logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data1_OutBUS,
  output logic [NUMBER_DATAWIDTH-1:0] CC_DEMUX_12_data2_OutBUS,
  output logic                        CC_DEMUX_12_valid1_Out,
  output logic                        CC_DEMUX_12_valid2_Out,
  output logic                        CC_DEMUX_12_last1_Out,
  output logic                        CC_DEMUX_12_last2_Out,
  input  logic                        CC_DEMUX_12_ready1_In,
  input  logic                        CC_DEMUX_12_ready2_In
`ifdef CC_DEMUX_12_COUNT_EN
  ,
  output logic [7:0]                  CC_DEMUX_12_count1_OutBUS,
  output logic [7:0]                  CC_DEMUX_12_count2_OutBUS
`endif
);

  typedef enum logic [1:0] {IDLE, ROUTE1, ROUTE2} state_t;

  state_t state, nextState;
  logic   targetTwo, accept, loadOne, loadTwo;

  // Target selection, upstream ready and next-state; select is only honoured at a packet start
  always_comb begin
    nextState = state;
    targetTwo = (state == IDLE) ? CC_DEMUX_12_select_In : (state == ROUTE2);
    CC_DEMUX_12_ready_Out = CC_DEMUX_12_RESET_InLow &&
      (targetTwo ? (!CC_DEMUX_12_valid2_Out || CC_DEMUX_12_ready2_In)
                 : (!CC_DEMUX_12_valid1_Out || CC_DEMUX_12_ready1_In));
    accept  = CC_DEMUX_12_valid_In && CC_DEMUX_12_ready_Out;
    loadOne = accept && !targetTwo;
    loadTwo = accept && targetTwo;
    if (accept)
      nextState = CC_DEMUX_12_last_In ? IDLE : (targetTwo ? ROUTE2 : ROUTE1);
  end

  // Packet-lock state register
  always_ff @(posedge CC_DEMUX_12_CLOCK_50 or negedge CC_DEMUX_12_RESET_InLow) begin
    if (!CC_DEMUX_12_RESET_InLow) state <= IDLE;
    else                          state <= nextState;
  end

  // Channel 1 output register: load on accept, otherwise empty on downstream handshake
  always_ff @(posedge CC_DEMUX_12_CLOCK_50 or negedge CC_DEMUX_12_RESET_InLow) begin
    if (!CC_DEMUX_12_RESET_InLow) begin
      CC_DEMUX_12_data1_OutBUS <= '0;
      CC_DEMUX_12_last1_Out    <= 1'b0;
      CC_DEMUX_12_valid1_Out   <= 1'b0;
    end else if (loadOne) begin
      CC_DEMUX_12_data1_OutBUS <= CC_DEMUX_12_data_InBUS;
      CC_DEMUX_12_last1_Out    <= CC_DEMUX_12_last_In;
      CC_DEMUX_12_valid1_Out   <= 1'b1;
    end else if (CC_DEMUX_12_ready1_In) begin
      CC_DEMUX_12_valid1_Out   <= 1'b0;
    end
  end

  // Channel 2 output register: load on accept, otherwise empty on downstream handshake
  always_ff @(posedge CC_DEMUX_12_CLOCK_50 or negedge CC_DEMUX_12_RESET_InLow) begin
    if (!CC_DEMUX_12_RESET_InLow) begin
      CC_DEMUX_12_data2_OutBUS <= '0;
      CC_DEMUX_12_last2_Out    <= 1'b0;
      CC_DEMUX_12_valid2_Out   <= 1'b0;
    end else if (loadTwo) begin
      CC_DEMUX_12_data2_OutBUS <= CC_DEMUX_12_data_InBUS;
      CC_DEMUX_12_last2_Out    <= CC_DEMUX_12_last_In;
      CC_DEMUX_12_valid2_Out   <= 1'b1;
    end else if (CC_DEMUX_12_ready2_In) begin
      CC_DEMUX_12_valid2_Out   <= 1'b0;
    end
  end

`ifdef CC_DEMUX_12_COUNT_EN
  // Per-channel output handshake counters, wrapping naturally at 8 bits
  always_ff @(posedge CC_DEMUX_12_CLOCK_50 or negedge CC_DEMUX_12_RESET_InLow) begin
    if (!CC_DEMUX_12_RESET_InLow) begin
      CC_DEMUX_12_count1_OutBUS <= '0;
      CC_DEMUX_12_count2_OutBUS <= '0;
    end else begin
      if (CC_DEMUX_12_valid1_Out && CC_DEMUX_12_ready1_In) CC_DEMUX_12_count1_OutBUS <= CC_DEMUX_12_count1_OutBUS + 8'd1;
      if (CC_DEMUX_12_valid2_Out && CC_DEMUX_12_ready2_In) CC_DEMUX_12_count2_OutBUS <= CC_DEMUX_12_count2_OutBUS + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cc_demux_12.sv
// tb_cc_demux_12: directed self-checking bench for cc_demux_12 (counter test active when CC_DEMUX_12_COUNT_EN is defined)
module tb_cc_demux_12;

  logic       clk = 1'b0;
  logic       rstN, vin, lin, sel, rdy, v1, v2, l1, l2, r1, r2;
  logic [7:0] din, d1, d2;
  int         checks = 0;
  int         errors = 0;
`ifdef CC_DEMUX_12_COUNT_EN
  logic [7:0] c1, c2;
`endif

  always #5 clk = ~clk;

  cc_demux_12 #(.NUMBER_DATAWIDTH(8)) dut (
    .CC_DEMUX_12_CLOCK_50(clk),
    .CC_DEMUX_12_RESET_InLow(rstN),
    .CC_DEMUX_12_data_InBUS(din),
    .CC_DEMUX_12_valid_In(vin),
    .CC_DEMUX_12_last_In(lin),
    .CC_DEMUX_12_select_In(sel),
    .CC_DEMUX_12_ready_Out(rdy),
    .CC_DEMUX_12_data1_OutBUS(d1),
    .CC_DEMUX_12_data2_OutBUS(d2),
    .CC_DEMUX_12_valid1_Out(v1),
    .CC_DEMUX_12_valid2_Out(v2),
    .CC_DEMUX_12_last1_Out(l1),
    .CC_DEMUX_12_last2_Out(l2),
    .CC_DEMUX_12_ready1_In(r1),
    .CC_DEMUX_12_ready2_In(r2)
`ifdef CC_DEMUX_12_COUNT_EN
    ,
    .CC_DEMUX_12_count1_OutBUS(c1),
    .CC_DEMUX_12_count2_OutBUS(c2)
`endif
  );

  task automatic beat(input logic [7:0] d, input logic s, input logic l);
    @(negedge clk);
    din = d; sel = s; lin = l; vin = 1'b1;
  endtask

  task automatic test_reset;
    rstN = 1'b0; vin = 1'b0; lin = 1'b0; sel = 1'b0; din = 8'h00; r1 = 1'b1; r2 = 1'b1;
    #12;
    checks++; if ({v1, v2, l1, l2} !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b exp 0000", {v1, v2, l1, l2}); end
    checks++; if ({d1, d2} !== 16'h0000) begin errors++; $display("FAIL reset_data got %h exp 0000", {d1, d2}); end
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", rdy); end
    @(negedge clk); rstN = 1'b1;
  endtask

  task automatic test_single;
    beat(8'hA5, 1'b1, 1'b1);
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", rdy); end
    @(posedge clk); #1;
    checks++; if ({v2, d2, l2, v1} !== {1'b1, 8'hA5, 1'b1, 1'b0}) begin errors++; $display("FAIL single_out got v2=%b d2=%h l2=%b v1=%b exp 1 a5 1 0", v2, d2, l2, v1); end
    @(negedge clk); vin = 1'b0;
    @(posedge clk); #1;
    checks++; if (v2 !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", v2); end
  endtask

  task automatic test_packet_lock;
    beat(8'h01, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1, v2} !== {1'b1, 8'h01, 1'b0, 1'b0}) begin errors++; $display("FAIL lock_b1 got v1=%b d1=%h l1=%b v2=%b exp 1 01 0 0", v1, d1, l1, v2); end
    beat(8'h02, 1'b1, 1'b0);
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1, v2} !== {1'b1, 8'h02, 1'b0, 1'b0}) begin errors++; $display("FAIL lock_b2 got v1=%b d1=%h l1=%b v2=%b exp 1 02 0 0", v1, d1, l1, v2); end
    beat(8'h03, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1, v2} !== {1'b1, 8'h03, 1'b1, 1'b0}) begin errors++; $display("FAIL lock_b3 got v1=%b d1=%h l1=%b v2=%b exp 1 03 1 0", v1, d1, l1, v2); end
    @(negedge clk); vin = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_backpressure;
    @(negedge clk); r1 = 1'b0;
    beat(8'h11, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({v1, d1} !== {1'b1, 8'h11}) begin errors++; $display("FAIL bp_first got v1=%b d1=%h exp 1 11", v1, d1); end
    beat(8'h22, 1'b1, 1'b1);
    #1;
    checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_stall_ready got %b exp 0", rdy); end
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1} !== {1'b1, 8'h11, 1'b0}) begin errors++; $display("FAIL bp_hold got v1=%b d1=%h l1=%b exp 1 11 0", v1, d1, l1); end
    @(negedge clk); r1 = 1'b1;
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", rdy); end
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1} !== {1'b1, 8'h22, 1'b1}) begin errors++; $display("FAIL bp_second got v1=%b d1=%h l1=%b exp 1 22 1", v1, d1, l1); end
    @(negedge clk); vin = 1'b0;
    @(posedge clk); #1;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", v1); end
  endtask

  task automatic test_concurrency;
    @(negedge clk); r2 = 1'b0;
    beat(8'h77, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if ({v2, d2} !== {1'b1, 8'h77}) begin errors++; $display("FAIL conc_stall2 got v2=%b d2=%h exp 1 77", v2, d2); end
    beat(8'h31, 1'b0, 1'b0);
    #1;
    checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL conc_ready got %b exp 1", rdy); end
    @(posedge clk); #1;
    checks++; if ({v1, d1, v2, d2} !== {1'b1, 8'h31, 1'b1, 8'h77}) begin errors++; $display("FAIL conc_b1 got v1=%b d1=%h v2=%b d2=%h exp 1 31 1 77", v1, d1, v2, d2); end
    beat(8'h32, 1'b1, 1'b1);
    @(posedge clk); #1;
    checks++; if ({v1, d1, l1, v2, d2} !== {1'b1, 8'h32, 1'b1, 1'b1, 8'h77}) begin errors++; $display("FAIL conc_b2 got v1=%b d1=%h l1=%b v2=%b d2=%h exp 1 32 1 1 77", v1, d1, l1, v2, d2); end
    @(negedge clk); vin = 1'b0; r2 = 1'b1;
    @(posedge clk); #1;
    checks++; if ({v1, v2} !== 2'b00) begin errors++; $display("FAIL conc_both_drain got %b exp 00", {v1, v2}); end
  endtask

  task automatic test_reset_mid;
    beat(8'h41, 1'b1, 1'b0);
    beat(8'h42, 1'b0, 1'b0);
    @(posedge clk); #1;
    checks++; if ({v2, d2, v1} !== {1'b1, 8'h42, 1'b0}) begin errors++; $display("FAIL rmid_b2 got v2=%b d2=%h v1=%b exp 1 42 0", v2, d2, v1); end
    #2; vin = 1'b0; rstN = 1'b0;
    #1;
    checks++; if ({v1, v2, d2, rdy} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin errors++; $display("FAIL rmid_async got v1=%b v2=%b d2=%h rdy=%b exp 0 0 00 0", v1, v2, d2, rdy); end
    @(negedge clk); rstN = 1'b1;
    din = 8'h51; sel = 1'b0; lin = 1'b1; vin = 1'b1;
    @(posedge clk); #1;
    checks++; if ({v1, d1, v2} !== {1'b1, 8'h51, 1'b0}) begin errors++; $display("FAIL rmid_restart got v1=%b d1=%h v2=%b exp 1 51 0", v1, d1, v2); end
    @(negedge clk); vin = 1'b0;
    @(posedge clk);
  endtask

`ifdef CC_DEMUX_12_COUNT_EN
  task automatic test_count;
    @(negedge clk); rstN = 1'b0; r1 = 1'b1; r2 = 1'b1;
    @(negedge clk); rstN = 1'b1;
    for (int i = 0; i < 257; i++) beat(i[7:0], 1'b0, 1'b1);
    @(negedge clk); vin = 1'b0;
    @(negedge clk);
    checks++; if ({c1, c2} !== {8'd1, 8'd0}) begin errors++; $display("FAIL count got c1=%0d c2=%0d exp 1 0", c1, c2); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_packet_lock;
    test_backpressure;
    test_concurrency;
    test_reset_mid;
`ifdef CC_DEMUX_12_COUNT_EN
    test_count;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
